// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and record layouts for the command master and its slaves.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CMD_W  = 1 + ADDR_W + 3 + DATA_W;
    localparam int RSP_W  = 2 + DATA_W;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        size;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic              err;
        logic              write;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > HSIZE_WORD) ? HSIZE_WORD : size;
    endfunction

    // Expects an already clamped size; misaligned low bits are silently dropped.
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr,
                                                     input logic [2:0] size);
        case (size)
            HSIZE_HALF: return {addr[ADDR_W-1:1], 1'b0};
            HSIZE_WORD: return {addr[ADDR_W-1:2], 2'b00};
            default:    return addr;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rsp_fifo.sv
// Synchronous response FIFO; a push is accepted on a full FIFO only when a pop frees a slot in the same cycle.
module ahb_rsp_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single-transfer master: command stream in, pipelined NONSEQ SINGLE transfers out,
// in-order responses back through a small FIFO.
module ahb_lite_cmd_master #(
    parameter int RSP_DEPTH = 4
) (
    input  logic        I_HCLK,
    input  logic        I_HRESET,
    input  logic        I_CMD_VALID,
    output logic        O_CMD_READY,
    input  logic        I_CMD_WRITE,
    input  logic [31:0] I_CMD_ADDR,
    input  logic [2:0]  I_CMD_SIZE,
    input  logic [31:0] I_CMD_WDATA,
    output logic        O_RSP_VALID,
    input  logic        I_RSP_READY,
    output logic [31:0] O_RSP_RDATA,
    output logic        O_RSP_ERR,
    output logic        O_RSP_WRITE,
    output logic [31:0] O_HADDR,
    output logic [1:0]  O_HTRANS,
    output logic        O_HWRITE,
    output logic [2:0]  O_HSIZE,
    output logic [2:0]  O_HBURST,
    output logic [3:0]  O_HPROT,
    output logic        O_HMASTLOCK,
    output logic [31:0] O_HWDATA,
    input  logic [31:0] I_HRDATA,
    input  logic        I_HREADY,
    input  logic        I_HRESP
);

    import ahb_lite_pkg::*;

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int FLT_W = CNT_W + 1;

    cmd_t             aph_cmd;
    logic             aph_valid;
    logic             dph_valid;
    logic             dph_write;
    logic [31:0]      dph_wdata;
    logic             cmd_fire;
    logic             completion;
    logic             rsp_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [FLT_W-1:0] in_flight;
    rsp_t             push_rsp;
    rsp_t             head_rsp;

    // Every accepted command owns a FIFO slot from acceptance until its response is popped.
    assign in_flight   = FLT_W'(aph_valid) + FLT_W'(dph_valid) + FLT_W'(fifo_count);
    assign rsp_pop     = O_RSP_VALID & I_RSP_READY;
    assign O_CMD_READY = ((in_flight - FLT_W'(rsp_pop)) < FLT_W'(RSP_DEPTH))
                       & ~(fifo_full & ~rsp_pop)
                       & (~aph_valid | I_HREADY);
    assign cmd_fire    = I_CMD_VALID & O_CMD_READY;
    assign completion  = dph_valid & I_HREADY;

    // A presented NONSEQ is never withdrawn: APH only changes on HREADY or while empty.
    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            aph_valid <= 1'b0;
            aph_cmd   <= '0;
        end else if (cmd_fire) begin
            aph_valid <= 1'b1;
            aph_cmd   <= '{write: I_CMD_WRITE,
                           addr:  align_addr(I_CMD_ADDR, clamp_size(I_CMD_SIZE)),
                           size:  clamp_size(I_CMD_SIZE),
                           wdata: I_CMD_WDATA};
        end else if (I_HREADY) begin
            aph_valid <= 1'b0;
        end
    end

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            dph_valid <= 1'b0;
            dph_write <= 1'b0;
            dph_wdata <= '0;
        end else if (I_HREADY) begin
            dph_valid <= aph_valid;
            if (aph_valid) begin
                dph_write <= aph_cmd.write;
                dph_wdata <= aph_cmd.wdata;
            end
        end
    end

    always_comb begin
        push_rsp       = '0;
        push_rsp.err   = I_HRESP;
        push_rsp.write = dph_write;
        push_rsp.rdata = (dph_write | I_HRESP) ? '0 : I_HRDATA;
    end

    ahb_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (I_HCLK),
        .rst   (I_HRESET),
        .push  (completion),
        .din   (push_rsp),
        .pop   (rsp_pop),
        .dout  (head_rsp),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Address/control fields keep their last values when APH empties; only HTRANS drops to IDLE.
    assign O_HTRANS    = aph_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign O_HADDR     = aph_cmd.addr;
    assign O_HWRITE    = aph_cmd.write;
    assign O_HSIZE     = aph_cmd.size;
    assign O_HWDATA    = dph_wdata;
    assign O_HBURST    = HBURST_SINGLE;
    assign O_HPROT     = HPROT_DEFAULT;
    assign O_HMASTLOCK = 1'b0;

    assign O_RSP_VALID = ~fifo_empty;
    assign O_RSP_RDATA = head_rsp.rdata;
    assign O_RSP_ERR   = head_rsp.err;
    assign O_RSP_WRITE = head_rsp.write;

endmodule
